sched_tx_dispatch: RTL

SCHED_TX_DISPATCH -- requirements
Module: sched_tx_dispatch

---
 rtl/tcp_misc_pkg.sv | 48 ++++
 rtl/sched_action_prio_enc.sv | 26 ++
 rtl/sched_tx_dispatch.sv | 135 +++++++++++++
 3 files changed

// File: rtl/tcp_misc_pkg.sv
// Shared scheduler/TX types: grant data, flag-clear commands and the TX dispatch action.
// Flag-command and dispatch-type literals carry prefixes so they cannot clash with FSM state names.
package tcp_misc_pkg;

    localparam int FLOWID_W = 8;

    typedef enum logic [1:0] {
        FLAG_NOP   = 2'd0,
        FLAG_SET   = 2'd1,
        FLAG_CLEAR = 2'd2
    } sched_flag_cmd_e;

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        logic                rt_flag;
        logic                ack_pend_flag;
        logic                data_pend_flag;
    } sched_data_struct;

    localparam int SCHED_DATA_STRUCT_W = $bits(sched_data_struct);

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        sched_flag_cmd_e     rt_pend_set_clear;
        sched_flag_cmd_e     ack_pend_set_clear;
        sched_flag_cmd_e     data_pend_set_clear;
    } sched_cmd_struct;

    localparam int SCHED_CMD_STRUCT_W = $bits(sched_cmd_struct);

    typedef enum logic [1:0] {
        DISP_RT   = 2'd0,
        DISP_ACK  = 2'd1,
        DISP_DATA = 2'd2
    } sched_dispatch_type_e;

    typedef struct packed {
        logic [FLOWID_W-1:0]  flowid;
        sched_dispatch_type_e dispatch_type;
    } sched_dispatch_struct;

    localparam int SCHED_DISPATCH_STRUCT_W = $bits(sched_dispatch_struct);

    function automatic sched_flag_cmd_e clear_if(input logic flag);
        return flag ? FLAG_CLEAR : FLAG_NOP;
    endfunction

endpackage

// File: rtl/sched_action_prio_enc.sv
// Picks the highest-priority pending action from a {rt, ack, data} mask.
// Returns its one-hot bit and dispatch type; an empty mask yields a zero one-hot.
module sched_action_prio_enc
    import tcp_misc_pkg::*;
(
    input  logic [2:0] mask_i,
    output logic [2:0] onehot_o,
    output logic [1:0] type_o
);

    always_comb begin
        onehot_o = 3'b000;
        type_o   = DISP_DATA;
        if (mask_i[2]) begin
            onehot_o = 3'b100;
            type_o   = DISP_RT;
        end else if (mask_i[1]) begin
            onehot_o = 3'b010;
            type_o   = DISP_ACK;
        end else if (mask_i[0]) begin
            onehot_o = 3'b001;
            type_o   = DISP_DATA;
        end
    end

endmodule

// File: rtl/sched_tx_dispatch.sv
// Takes one scheduler grant at a time, issues its RT/ACK/DATA actions in priority order,
// then sends a single flag-clear command back to the scheduler before accepting the next grant.
module sched_tx_dispatch
    import tcp_misc_pkg::*;
#(
    parameter int ACK_PIGGYBACK = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sched_tx_req_val,
    input  logic [SCHED_DATA_STRUCT_W-1:0]     sched_tx_req_data,
    output logic                               sched_tx_req_rdy,
    output logic                               dispatch_val,
    output logic [SCHED_DISPATCH_STRUCT_W-1:0] dispatch_data,
    input  logic                               dispatch_rdy,
    output logic                               tx_sched_update_val,
    output logic [SCHED_CMD_STRUCT_W-1:0]      tx_sched_update_cmd,
    input  logic                               sched_tx_update_rdy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_CLEAR
    } state_e;

    state_e              state_q;
    logic [2:0]          mask_q;
    logic                req_rdy_q;
    logic                disp_val_q;
    logic                upd_val_q;

    logic [FLOWID_W-1:0] flow_q;
    logic                rt_q;
    logic                ack_q;

    sched_data_struct    req_s;
    logic [2:0]          mask_d;
    logic [2:0]          rem_d;
    logic [2:0]          pick_oh;
    logic [1:0]          pick_type;
    logic                accept;
    logic                disp_fire;
    logic                upd_fire;
    sched_cmd_struct     cmd_s;

    assign req_s     = sched_tx_req_data;
    assign accept    = sched_tx_req_val & req_rdy_q;
    assign disp_fire = disp_val_q & dispatch_rdy;
    assign upd_fire  = upd_val_q & sched_tx_update_rdy;

    // A piggybacked ACK rides on the DATA action, so it never gets its own dispatch slot.
    assign mask_d = {req_s.rt_flag,
                     req_s.ack_pend_flag & ~((ACK_PIGGYBACK != 0) & req_s.data_pend_flag),
                     req_s.data_pend_flag};

    sched_action_prio_enc u_prio (
        .mask_i   (mask_q),
        .onehot_o (pick_oh),
        .type_o   (pick_type)
    );

    assign rem_d = mask_q & ~pick_oh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mask_q     <= 3'b000;
            req_rdy_q  <= 1'b1;
            disp_val_q <= 1'b0;
            upd_val_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        req_rdy_q <= 1'b0;
                        mask_q    <= mask_d;
                        if (mask_d != 3'b000) begin
                            state_q    <= ST_DISPATCH;
                            disp_val_q <= 1'b1;
                        end else begin
                            state_q   <= ST_CLEAR;
                            upd_val_q <= 1'b1;
                        end
                    end
                end
                ST_DISPATCH: begin
                    // After the last action retires, one idle cycle separates dispatch from the command.
                    if (disp_fire) begin
                        mask_q <= rem_d;
                        if (rem_d == 3'b000) begin
                            disp_val_q <= 1'b0;
                        end
                    end else if (!disp_val_q) begin
                        state_q   <= ST_CLEAR;
                        upd_val_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (upd_fire) begin
                        state_q   <= ST_IDLE;
                        upd_val_q <= 1'b0;
                        req_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            flow_q <= req_s.flowid;
            rt_q   <= req_s.rt_flag;
            ack_q  <= req_s.ack_pend_flag;
        end
    end

    // The clear uses the original ACK flag, so a piggybacked ACK is still cleared.
    always_comb begin
        cmd_s.flowid              = flow_q;
        cmd_s.rt_pend_set_clear   = clear_if(rt_q);
        cmd_s.ack_pend_set_clear  = clear_if(ack_q);
        cmd_s.data_pend_set_clear = FLAG_NOP;
    end

    assign sched_tx_req_rdy    = req_rdy_q;
    assign dispatch_val        = disp_val_q;
    assign dispatch_data       = {flow_q, pick_type};
    assign tx_sched_update_val = upd_val_q;
    assign tx_sched_update_cmd = cmd_s;

endmodule
